// File: rtl/ci_dispatch_pkg.sv
// Shared types and constants for the custom-instruction dispatch stage.
// Used by ci_dispatch and ci_watchdog. The watchdog is built only when the
// CI_TIMEOUT_EN macro is defined.
package ci_dispatch_pkg;

    // Width of the CPU operands and of every slot result.
    localparam int RESULT_W = 32;

    // Value returned to the CPU when the addressed slot never answers.
    localparam logic [RESULT_W-1:0] CI_TIMEOUT_RESULT = 32'hFFFF_FFFF;

    // Dispatch controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } ci_state_e;

    // Slot offset of a custom-instruction number. The subtraction is 8-bit
    // unsigned, so values below the base wrap to large offsets. The caller
    // rejects those by also requiring ci >= base.
    function automatic logic [7:0] ci_slot_offset(input logic [7:0] ci,
                                                  input logic [7:0] base);
        return ci - base;
    endfunction

endpackage

// File: rtl/ci_watchdog.sv
// Watchdog counter for the dispatch stage's WAIT state.
// This block is instantiated only when CI_TIMEOUT_EN is defined.
// clear resets the count. inc advances it by one. expired is high while
// the count equals TIMEOUT-1, and the counter holds there instead of
// wrapping.
module ci_watchdog
    import ci_dispatch_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int unsigned    CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    // Count WAIT cycles. The count is cleared on ISSUE and saturates at the
    // expiry value.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/ci_dispatch.sv
// Custom-instruction dispatch stage.
// The block decodes ciN, latches the CPU operands, and pulses slotStart for
// the addressed slot. It then waits for that slot's slotDone and returns the
// slot result to the CPU as a one-cycle done/result pulse. An unmapped ciN
// gets a zero response after one cycle.
// Optional feature: define CI_TIMEOUT_EN to enable the WAIT watchdog
// (ci_watchdog). When the watchdog expires, the block answers 32'hFFFF_FFFF
// and sets the sticky timeoutFlag.
module ci_dispatch
    import ci_dispatch_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = 4,
    parameter logic [7:0]  BASE_ID   = 8'h00,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic [7:0]                    ciN,
    input  logic [RESULT_W-1:0]           valueA,
    input  logic [RESULT_W-1:0]           valueB,
    output logic                          done,
    output logic [RESULT_W-1:0]           result,
    output logic                          busy,
    output logic                          timeoutFlag,
    output logic [NUM_SLOTS-1:0]          slotStart,
    output logic [RESULT_W-1:0]           slotValueA,
    output logic [RESULT_W-1:0]           slotValueB,
    input  logic [NUM_SLOTS-1:0]          slotDone,
    input  logic [RESULT_W*NUM_SLOTS-1:0] slotResult
);

    // Parameter legality checks, evaluated at elaboration.
    if (NUM_SLOTS < 1 || NUM_SLOTS > 16) begin : g_bad_num_slots
        $error("ci_dispatch: NUM_SLOTS must be in 1..16");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("ci_dispatch: TIMEOUT must be at least 2");
    end

    // Number of slots as a 9-bit value, for comparison against the 8-bit offset.
    localparam logic [8:0] SLOT_LIMIT = 9'(NUM_SLOTS);

    ci_state_e             state;
    logic [NUM_SLOTS-1:0]  slot_sel;      // one-hot of the slot owning the transaction

    logic [7:0]            ci_offset;
    logic                  ci_mapped;
    logic [NUM_SLOTS-1:0]  ci_onehot;

    logic                  sel_done;
    logic [RESULT_W-1:0]   sel_result;

    // Decode the incoming instruction number into a mapped flag and a
    // one-hot slot select.
    always_comb begin
        // NOTE: every output of this block gets a default before any
        // condition, so no path leaves a value held and no latch is inferred.
        ci_offset = ci_slot_offset(ciN, BASE_ID);
        ci_mapped = (ciN >= BASE_ID) && ({1'b0, ci_offset} < SLOT_LIMIT);
        ci_onehot = '0;
        for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            if (ci_mapped && (ci_offset == 8'(i))) begin
                ci_onehot[i] = 1'b1;
            end
        end
    end

    // Pick the completion and result of the slot that owns the transaction.
    // Strobes from the other slots are masked off here.
    always_comb begin
        sel_done   = |(slotDone & slot_sel);
        sel_result = '0;
        for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            if (slot_sel[i]) begin
                sel_result = slotResult[RESULT_W*i +: RESULT_W];
            end
        end
    end

`ifdef CI_TIMEOUT_EN
    logic wd_expired;

    ci_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (state == ISSUE),
        .inc     ((state == WAIT) && !sel_done),
        .expired (wd_expired)
    );
`else
    assign timeoutFlag = 1'b0;
`endif

    // Dispatch controller. All CPU-facing and slot-facing outputs are
    // registered here.
    always_ff @(posedge clock) begin
        // NOTE: all state is updated with non-blocking assignments, so every
        // branch below sees the values from before this clock edge.
        if (reset) begin
            state      <= IDLE;
            done       <= 1'b0;
            result     <= '0;
            busy       <= 1'b0;
            slotStart  <= '0;
            slotValueA <= '0;
            slotValueB <= '0;
            slot_sel   <= '0;
`ifdef CI_TIMEOUT_EN
            timeoutFlag <= 1'b0;
`endif
        end else begin
            // Pulses last one cycle. result is forced to zero whenever
            // done is low.
            done      <= 1'b0;
            result    <= '0;
            slotStart <= '0;

            case (state)
                IDLE: begin
                    if (start) begin
                        slotValueA <= valueA;
                        slotValueB <= valueB;
                        slot_sel   <= ci_onehot;
                        busy       <= 1'b1;
                        if (ci_mapped) begin
                            state     <= ISSUE;
                            slotStart <= ci_onehot;
                        end else begin
                            // No slot owns this number; answer zero right away.
                            state <= RESP;
                            done  <= 1'b1;
                        end
                    end
                end

                ISSUE: begin
                    if (sel_done) begin
                        state  <= RESP;
                        done   <= 1'b1;
                        result <= sel_result;
                    end else begin
                        state <= WAIT;
                    end
                end

                WAIT: begin
                    // A real answer takes priority over watchdog expiry in the same cycle.
                    if (sel_done) begin
                        state  <= RESP;
                        done   <= 1'b1;
                        result <= sel_result;
                    end
`ifdef CI_TIMEOUT_EN
                    else if (wd_expired) begin
                        state       <= RESP;
                        done        <= 1'b1;
                        result      <= CI_TIMEOUT_RESULT;
                        timeoutFlag <= 1'b1;
                    end
`endif
                end

                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ci_dispatch.sv
// Testbench for ci_dispatch using a queue-based scoreboard.
// The driver issues each request and pushes the expected response (result,
// completion cycle, timeout flag) into a queue. The monitor runs on every
// falling edge and pops and compares whenever the DUT raises done. The slots
// are emulated here. Their latency and data are chosen per request, and the
// other slots inject noise.
// If CI_TIMEOUT_EN is defined, silent-slot watchdog requests are added.
module tb_ci_dispatch;

    localparam int          NS      = 4;
    localparam logic [7:0]  BASE_ID = 8'h10;
    localparam int          TIMEOUT = 8;
`ifdef CI_TIMEOUT_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic [7:0]        ciN;
    logic [31:0]       valueA, valueB;
    logic              done;
    logic [31:0]       result;
    logic              busy;
    logic              timeoutFlag;
    logic [NS-1:0]     slotStart;
    logic [31:0]       slotValueA, slotValueB;
    logic [NS-1:0]     slotDone;
    logic [32*NS-1:0]  slotResult;

    ci_dispatch #(
        .NUM_SLOTS (NS),
        .BASE_ID   (BASE_ID),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .ciN         (ciN),
        .valueA      (valueA),
        .valueB      (valueB),
        .done        (done),
        .result      (result),
        .busy        (busy),
        .timeoutFlag (timeoutFlag),
        .slotStart   (slotStart),
        .slotValueA  (slotValueA),
        .slotValueB  (slotValueB),
        .slotDone    (slotDone),
        .slotResult  (slotResult)
    );

    always #5 clock = ~clock;

    // Cycle n is the interval after the n-th rising edge.
    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Scoreboard entry: expected response of one accepted request.
    typedef struct {
        logic [31:0] res;
        int unsigned due;
        logic        flag;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    bit   mon_en = 1'b0;
    logic model_flag = 1'b0;   // sticky timeout flag as the model sees it

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (mon_en) begin
            if (done) begin
                check("done_has_pending_request", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    mon_e = sb_q.pop_front();
                    check("result", result, mon_e.res);
                    check("done_cycle", cyc, mon_e.due);
                    check("timeout_flag", 32'(timeoutFlag), 32'(mon_e.flag));
                end
            end else begin
                check("result_zero_without_done", result, 32'd0);
            end
        end
    end

    task automatic randomize_slot_results();
        for (int j = 0; j < NS; j++) slotResult[32*j +: 32] = $urandom;
    endtask

    // Run one request. The task must be entered at a falling edge in an idle
    // cycle, and it returns at the falling edge of the next idle cycle, so
    // consecutive calls are back-to-back.
    task automatic run_txn(input logic [7:0] ci, input logic [31:0] a, input logic [31:0] b,
                           input int k, input bit silent, input logic [31:0] val);
        bit            mapped;
        int            slot;
        int            lat;
        int            n;
        int unsigned   t0;
        logic [NS-1:0] oh;
        logic [31:0]   exp_res;
        exp_t          e;

        mapped = (int'(ci) >= int'(BASE_ID)) && (int'(ci) - int'(BASE_ID) < NS);
        slot   = int'(ci) - int'(BASE_ID);
        oh     = mapped ? NS'(1 << slot) : '0;

        // Reference rules: unmapped -> 0 after 1 cycle; answered -> slot data
        // after 2+k cycles; silent slot -> all ones after 2+TIMEOUT cycles.
        if (!mapped) begin
            exp_res = 32'd0;
            lat     = 1;
        end else if (silent) begin
            exp_res    = 32'hFFFF_FFFF;
            lat        = 2 + TIMEOUT;
            model_flag = 1'b1;
        end else begin
            exp_res = val;
            lat     = 2 + k;
        end

        start  = 1'b1;
        ciN    = ci;
        valueA = a;
        valueB = b;
        t0     = cyc;
        e.res  = exp_res;
        e.due  = t0 + 32'(lat);
        e.flag = model_flag;
        sb_q.push_back(e);

        n = 0;
        while (1) begin
            @(negedge clock);
            n++;
            if (!busy) break;
            if (n > 40) begin
                check("busy_cycle_budget", 32'(n), 32'(lat + 1));
                break;
            end
            check("slot_valueA_stable", slotValueA, a);
            check("slot_valueB_stable", slotValueB, b);
            check("slot_start", 32'(slotStart), (n == 1) ? 32'(oh) : 32'd0);

            // While busy, the CPU side sends junk requests that must be ignored.
            start  = 1'($urandom_range(0, 1));
            ciN    = 8'($urandom_range(0, 255));
            valueA = $urandom;
            valueB = $urandom;

            // Other slots send random noise. The addressed slot answers in cycle 1+k.
            slotDone = NS'($urandom) & ~oh;
            randomize_slot_results();
            if (mapped && !silent && n == 1 + k) begin
                slotDone            = slotDone | oh;
                slotResult[32*slot +: 32] = val;
            end
            // For a silent slot, a late answer arrives in the response cycle and must be ignored.
            if (mapped && silent && n == lat) slotDone = slotDone | oh;
        end
        check("busy_span", 32'(n), 32'(lat + 1));
        start    = 1'b0;
        slotDone = '0;
    endtask

    // Reset a request while it is in WAIT. There must be no done pulse, and
    // the DUT must be idle with cleared outputs afterwards.
    task automatic reset_in_wait();
        start  = 1'b1;
        ciN    = BASE_ID + 8'd1;
        valueA = 32'hDEAD_0001;
        valueB = 32'hDEAD_0002;
        repeat (3) begin
            @(negedge clock);
            start    = 1'b0;
            slotDone = '0;
        end
        check("wait_busy_before_reset", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        reset      = 1'b0;
        model_flag = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_slot_valueA", slotValueA, 32'd0);
        check("abort_timeout_flag", 32'(timeoutFlag), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        logic [7:0] ci;
        bit         silent;

        reset      = 1'b1;
        start      = 1'b0;
        ciN        = '0;
        valueA     = '0;
        valueB     = '0;
        slotDone   = '0;
        slotResult = '0;
        repeat (3) @(negedge clock);
        check("reset_done", 32'(done), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_slot_start", 32'(slotStart), 32'd0);
        check("reset_slot_valueA", slotValueA, 32'd0);
        check("reset_slot_valueB", slotValueB, 32'd0);
        check("reset_timeout_flag", 32'(timeoutFlag), 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Directed requests
        run_txn(8'h12, 32'd5, 32'h0000_0101, 0, 1'b0, 32'h0000_1234);
        run_txn(8'h11, 32'hA, 32'hB, 5, 1'b0, 32'h0000_CAFE);
        run_txn(8'h20, 32'h1, 32'h2, 0, 1'b0, 32'h5555_5555);
        run_txn(8'h0F, 32'h3, 32'h4, 0, 1'b0, 32'h6666_6666);     // just below the base
        run_txn(8'h13, 32'h5, 32'h6, 2, 1'b0, 32'h0BAD_F00D);     // last slot
        run_txn(8'h14, 32'h7, 32'h8, 0, 1'b0, 32'h7777_7777);     // just past the last slot
        run_txn(8'h10, 32'h9, 32'hA, TIMEOUT, 1'b0, 32'h1357_9BDF); // answers on the expiry cycle
        if (WD) run_txn(8'h13, 32'h11, 32'h22, 0, 1'b1, 32'h0);
        reset_in_wait();
        run_txn(8'h12, 32'h33, 32'h44, 3, 1'b0, 32'h2468_ACE0);

        // Random requests
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) == 0) ci = 8'($urandom_range(0, 255));
            else ci = BASE_ID + 8'($urandom_range(0, NS - 1));
            silent = WD && ($urandom_range(0, 7) == 0);
            run_txn(ci, $urandom, $urandom, int'($urandom_range(0, TIMEOUT)), silent, $urandom);
        end

        repeat (2) @(negedge clock);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/ci_dispatch.md
# ci_dispatch

Custom-instruction dispatch stage between the CPU's custom-instruction port and the profiling/accelerator custom-instruction units (e.g. the profile counter block). Decodes `ciN`, latches operands, issues a one-cycle start to the addressed slot, waits for that slot's `done`, and returns its result to the CPU as a single-cycle `done`/`result` pulse. An optional watchdog terminates transactions whose slot never answers.

## Interface
Parameters:
- `NUM_SLOTS`, 4: number of downstream custom-instruction units (1..16).
- `BASE_ID`, 8'h00: `ciN` value mapped to slot 0; slot i answers `BASE_ID+i`.
- `TIMEOUT`, 1024: watchdog limit in WAIT cycles (≥2); used only with `CI_TIMEOUT_EN`.

Ports:
- `clock` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: CPU request strobe, one cycle.
- `ciN` in 8: custom-instruction number.
- `valueA`, `valueB` in 32: CPU operands.
- `done` out 1: one-cycle completion pulse to CPU.
- `result` out 32: response data; 0 whenever `done`=0.
- `busy` out 1: high in every state except IDLE.
- `timeoutFlag` out 1: sticky; set on watchdog expiry, cleared by `reset`.
- `slotStart` out NUM_SLOTS: one-hot start, one cycle.
- `slotValueA`, `slotValueB` out 32: latched operands, stable from ISSUE through RESP.
- `slotDone` in NUM_SLOTS: per-slot completion.
- `slotResult` in 32*NUM_SLOTS: slot i result on bits [32i+31:32i].

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: on `start`=1, latch `valueA`, `valueB`, slot index `ciN-BASE_ID` (8-bit subtract, unsigned). Mapped (`BASE_ID ≤ ciN < BASE_ID+NUM_SLOTS`, no wrap past 8'hFF) → ISSUE; unmapped → RESP with response 0.
- ISSUE: `slotStart[idx]`=1 for exactly this cycle; clear watchdog. If `slotDone[idx]`=1 this cycle, capture `slotResult[idx]` → RESP; else → WAIT.
- WAIT: on `slotDone[idx]`, capture that slice → RESP. Otherwise increment watchdog.
- RESP: `done`=1, `result`=captured value for one cycle → IDLE.
- `start` outside IDLE is ignored (CPU stalls on `busy`). `slotDone` of non-addressed slots, or in IDLE/RESP, ignored.
- `slotDone[idx]` and watchdog expiry in the same cycle: done wins, real result returned, flag not set.
- Reset values: state IDLE; `done`, `busy`, `timeoutFlag`, `slotStart` 0; `result`, `slotValueA`, `slotValueB` 0. Reset in any state aborts with no `done` pulse.

## Timing
- `start` at cycle 0 → `slotStart` at cycle 1.
- Slot done in cycle 1 → CPU `done` at cycle 2 (minimum mapped latency 2).
- Slot done in cycle 1+k → CPU `done` at 2+k.
- Unmapped `ciN`: `done` at cycle 1, `result`=0.
- Watchdog: WAIT count k-1 at cycle 1+k; at count TIMEOUT-1 with no done → RESP; `done` at cycle 2+TIMEOUT.
- Back-to-back: new `start` accepted the cycle after RESP.

## Configuration
- `CI_TIMEOUT_EN` defined: watchdog active; expiry → RESP with `result`=32'hFFFF_FFFF, `timeoutFlag` set.
- Not defined: no watchdog logic; WAIT holds until `slotDone[idx]`; `timeoutFlag` tied 0; `TIMEOUT` unused.

## Structure
- Package `ci_dispatch_pkg`: state enum (IDLE, ISSUE, WAIT, RESP), `CI_TIMEOUT_RESULT` = 32'hFFFF_FFFF, result width 32.
- Sub-module `ci_watchdog`: clear/increment/expire counter, width $clog2(TIMEOUT); instantiated only under `CI_TIMEOUT_EN`.

## Test plan
- BASE_ID=8'h10, `ciN`=8'h12, valueA=5, valueB=32'h0000_0101; slot 2 returns done in cycle 1 with 32'h1234 → `slotStart`=4'b0100 at 1, `done` with 32'h1234 at cycle 2, slot operands match.
- Slot 1 answers 5 cycles after ISSUE with 32'hCAFE → `done` at cycle 7; `busy` high cycles 1–7; `result`=0 except cycle 7.
- `ciN`=8'h20 (unmapped) → no `slotStart`; `done` at cycle 1, `result`=0.
- `CI_TIMEOUT_EN`, TIMEOUT=8, slot silent → `done` at cycle 10, `result`=32'hFFFF_FFFF, `timeoutFlag`=1 until reset; late `slotDone` ignored.
- `reset` in WAIT, then `start` during WAIT/RESP of a second transaction → no `done` from aborted op, state IDLE next cycle; second `start` ignored and exactly one `done` per accepted request.
